// File: rtl/alu_pkg.sv
// Shared ALU control codes, multi-cycle classification and sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0001;
  localparam logic [3:0] ALU_SUB     = 4'b0010;
  localparam logic [3:0] ALU_AND     = 4'b0011;
  localparam logic [3:0] ALU_OR      = 4'b0100;
  localparam logic [3:0] ALU_MUL     = 4'b0110;
  localparam logic [3:0] ALU_RELU    = 4'b0111;
  localparam logic [3:0] ALU_MAXPOOL = 4'b1000;
  localparam logic [3:0] ALU_FC      = 4'b1001;
  localparam logic [3:0] ALU_CONV    = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic logic is_multicycle(input logic [3:0] code);
    return (code == ALU_MUL) || (code == ALU_MAXPOOL) ||
           (code == ALU_FC)  || (code == ALU_CONV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// EX-stage <-> sequencer signal bundle; state_o exposes the FSM for observation.
interface alu_op_sequencer_if;
  import alu_pkg::*;

  // valid_i marks an instruction present in EX; it is held by the pipeline
  // while stall_o is high and leaves EX in the cycle result_valid_o is high.
  logic        valid_i;
  logic [3:0]  alu_ctrl_i;
  logic        flush_i;
  logic [31:0] unit_result_i;
  logic        stall_o;
  logic        unit_start_o;
  logic [3:0]  unit_sel_o;
  logic        busy_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  seq_state_t  state_o;

  modport master (
    output valid_i, alu_ctrl_i, flush_i, unit_result_i,
    input  stall_o, unit_start_o, unit_sel_o, busy_o, result_valid_o, result_o, state_o
  );

  modport slave (
    input  valid_i, alu_ctrl_i, flush_i, unit_result_i,
    output stall_o, unit_start_o, unit_sel_o, busy_o, result_valid_o, result_o, state_o
  );
endinterface

// File: rtl/alu_lat_lookup.sv
// Maps an ALU control code to its latency minus one; unknown codes give 0.
module alu_lat_lookup
  import alu_pkg::*;
#(
  parameter int LAT_MUL  = 3,
  parameter int LAT_POOL = 4,
  parameter int LAT_FC   = 16,
  parameter int LAT_CONV = 36,
  parameter int CNT_W    = 8
) (
  input  logic [3:0]       code_i,
  output logic [CNT_W-1:0] lat_m1_o,
  output logic             multi_o
);

  always_comb begin
    lat_m1_o = '0;
    multi_o  = is_multicycle(code_i);
    case (code_i)
      ALU_MUL:     lat_m1_o = CNT_W'(LAT_MUL - 1);
      ALU_MAXPOOL: lat_m1_o = CNT_W'(LAT_POOL - 1);
      ALU_FC:      lat_m1_o = CNT_W'(LAT_FC - 1);
      ALU_CONV:    lat_m1_o = CNT_W'(LAT_CONV - 1);
      default:     lat_m1_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Stalls the pipeline around multi-cycle ALU ops, counts their latency and captures the result.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int LAT_MUL  = 3,
  parameter int LAT_POOL = 4,
  parameter int LAT_FC   = 16,
  parameter int LAT_CONV = 36,
  parameter int CNT_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_op_sequencer_if.slave bus
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic             start_q, start_d;
  logic             rv_q, rv_d;
  logic [31:0]      result_q, result_d;
  logic             stall;
  logic [CNT_W-1:0] lat_m1;
  logic             multi;

  alu_lat_lookup #(
    .LAT_MUL (LAT_MUL),
    .LAT_POOL(LAT_POOL),
    .LAT_FC  (LAT_FC),
    .LAT_CONV(LAT_CONV),
    .CNT_W   (CNT_W)
  ) u_lat (
    .code_i  (bus.alu_ctrl_i),
    .lat_m1_o(lat_m1),
    .multi_o (multi)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    start_d  = 1'b0;
    rv_d     = 1'b0;
    result_d = result_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i && multi) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = lat_m1;
          sel_d   = bus.alu_ctrl_i;
          start_d = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d  = DONE;
          rv_d     = 1'b1;
          result_d = bus.unit_result_i;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // DONE never accepts, so the held instruction cannot be launched twice.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A squash overrides everything: no launch, no result, pipeline released.
    if (bus.flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      start_d  = 1'b0;
      rv_d     = 1'b0;
      result_d = result_q;
      stall    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      start_q  <= 1'b0;
      rv_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      start_q  <= start_d;
      rv_q     <= rv_d;
      result_q <= result_d;
    end
  end

  assign bus.stall_o        = stall && !rst_i;
  assign bus.unit_start_o   = start_q;
  assign bus.unit_sel_o     = sel_q;
  assign bus.busy_o         = (state_q == BUSY);
  assign bus.result_valid_o = rv_q;
  assign bus.result_o       = result_q;
  assign bus.state_o        = state_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequences the EX-stage ALU for multi-cycle custom operations: MUL, MaxPool, FC and Conv2d. It sits between the ALU control decode (the 4-bit ALU control code) and the pipeline hazard unit. For a multi-cycle op it holds the pipeline via stall, launches the selected functional unit, counts that op's latency, captures the unit result and releases the pipeline. Single-cycle ops (ADD, SUB, AND, OR, Relu, unknown codes) pass through with no stall.

## Interface
Parameters:
- LAT_MUL, 3, busy cycles for MUL
- LAT_POOL, 4, busy cycles for MaxPool
- LAT_FC, 16, busy cycles for FC
- LAT_CONV, 36, busy cycles for Conv2d
- CNT_W, 8, latency counter width; every LAT_* must be in 1..2^CNT_W-1

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- valid_i  in  1  EX stage holds a valid instruction
- alu_ctrl_i  in  4  ALU control code of the EX instruction
- flush_i  in  1  EX instruction squashed (branch/exception)
- unit_result_i  in  32  result bus of the multi-cycle units
- stall_o  out  1  freeze PC/IF/ID/EX (combinational)
- unit_start_o  out  1  one-cycle launch pulse to the selected unit
- unit_sel_o  out  4  latched control code of the op in flight
- busy_o  out  1  state is BUSY
- result_valid_o  out  1  result_o valid; instruction may leave EX
- result_o  out  32  captured multi-cycle result

## Operation
- Multi-cycle codes: 0110 (MUL), 1000 (MaxPool), 1001 (FC), 1010 (Conv2d). All other codes are single-cycle and are never stalled.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if valid_i & multi-cycle & !flush_i:
  - stall_o=1 in that cycle
  - at the next edge: unit_sel_o <= alu_ctrl_i, counter <= LAT-1, unit_start_o <= 1, go to BUSY
- BUSY:
  - stall_o=1 and busy_o=1
  - counter decrements each cycle
  - on the cycle counter==0: result_o <= unit_result_i at the edge, result_valid_o <= 1, go to DONE
  - alu_ctrl_i and valid_i are ignored while in BUSY
- DONE:
  - stall_o=0 and result_valid_o=1 for exactly this one cycle
  - the held instruction advances; always return to IDLE
  - no acceptance occurs in DONE, so the same instruction is never re-launched
- flush_i has priority in every state:
  - stall_o drops combinationally
  - next state is IDLE; counter cleared; result_valid_o not raised; result_o unchanged
  - a flush on the acceptance cycle prevents unit_start_o
- unit_start_o is high only in the first BUSY cycle.
- Latency per op is selected from the LAT_* parameters; the counter is CNT_W bits wide and never wraps.
- Reset (asynchronous, any state, mid-operation included):
  - state IDLE, counter 0
  - stall_o=0, unit_start_o=0, unit_sel_o=0, busy_o=0, result_valid_o=0, result_o=0
  - stall_o is forced 0 while rst_i is high

## Timing
- Multi-cycle op accepted at cycle T:
  - unit_start_o=1 at T+1
  - BUSY for cycles T+1..T+LAT
  - result_o sampled at the end of T+LAT
  - DONE at T+LAT+1
- EX occupancy is LAT+2 cycles; stall_o is high for T..T+LAT (LAT+1 cycles).
- A back-to-back multi-cycle op arriving at T+LAT+2 is accepted immediately (IDLE).
- Single-cycle op: zero added latency; stall_o stays 0.

## Structure
- Shared package alu_pkg holds:
  - ALU control code constants: ADD 0001, SUB 0010, AND 0011, OR 0100, MUL 0110, RELU 0111, MAXPOOL 1000, FC 1001, CONV 1010
  - is_multicycle function
  - seq_state_t enum {IDLE, BUSY, DONE}
- One sub-module, alu_lat_lookup: combinational map from code plus LAT_* parameters to CNT_W-bit latency-minus-one. Unknown codes map to 0 and are flagged single-cycle.
- Everything else (FSM, counter, result register) lives in alu_op_sequencer.

## Test plan
- ADD (0001) valid for 5 cycles -> stall_o never 1, unit_start_o never 1, result_valid_o 0.
- MUL (0110) at T, unit_result_i=0x0000_0042 at T+3 -> unit_start_o at T+1 only; stall_o 1 for T..T+3; result_valid_o=1, result_o=0x42 at T+4; IDLE at T+5.
- Conv2d (1010) with LAT_CONV=36 -> busy_o high exactly 36 cycles; DONE at T+37; a FC (1001) presented at T+38 starts a fresh 16-cycle run.
- MaxPool (1000) accepted, flush_i=1 at T+2 -> stall_o 0 in T+2, IDLE at T+3, result_valid_o never 1, result_o holds its prior value.
- FC accepted, rst_i asserted asynchronously mid-BUSY (between edges) -> all outputs 0 immediately; after release, a MUL completes with normal T+4 timing.
- valid_i=1 with MUL and flush_i=1 in the same IDLE cycle -> no launch, unit_start_o 0, state stays IDLE.
